keccak_feeder: RTL and testbench
================================

# keccak_feeder

Consumer stage between the 64-bit read side of the OCM bus FIFO and the Keccak core input. On `start`, it pops exactly ceil(`msg_len`/8) 64-bit words from the FIFO and presents each to the Keccak core with a valid/backpressure handshake. It marks the final word with `is_last` and `byte_num`, and appends the zero-byte terminator word the core requires when the length is a multiple of 8. It replaces ad-hoc word capture in the data FSM with a length-driven, stall-safe streamer.

## Interface
- `LEN_W`, 32, width of message length in bytes

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request to stream a message; ignored while `busy`
- `msg_len`  in  LEN_W  message length in bytes, sampled on accepted `start`
- `fifo_empty`  in  1  FIFO has no readable word
- `fifo_read_en`  out  1  one-cycle pop; data valid on `fifo_read_data` the following cycle
- `fifo_read_data`  in  64  FIFO output word
- `keccak_input`  out  64  word to Keccak core
- `in_ready`  out  1  word valid to Keccak core
- `is_last`  out  1  qualifies the final word of the message
- `byte_num`  out  3  valid bytes in the final word (0..7); 0 on non-final words
- `buffer_full`  in  1  Keccak core cannot accept this cycle
- `busy`  out  1  message in progress
- `done`  out  1  one-cycle pulse after the final word is accepted
- `words_sent`  out  LEN_W  words accepted by the core for the current message, including the pad word

## Operation
- Registers latched on start: `full_words` = `msg_len`>>3, `rem` = `msg_len`[2:0], `fifo_words` = `full_words` + (`rem`!=0). Internal counter `rd_cnt` counts popped words.
- State `IDLE`:
  - When `start` is high, latch the length, clear `words_sent`, and set `busy`.
  - If `fifo_words`==0, go to `PAD`; otherwise go to `FETCH`.
- State `FETCH`: if `~fifo_empty`, pulse `fifo_read_en`, increment `rd_cnt`, and go to `CAPTURE`. Otherwise wait with no pop.
- State `CAPTURE`:
  - Load `keccak_input` from `fifo_read_data`, unmodified, with no byte reordering.
  - Set `in_ready`=1.
  - If this is the final FIFO word and `rem`!=0, set `is_last`=1 and `byte_num`=`rem`. Otherwise set both to 0.
  - Go to `SEND`.
- State `SEND`:
  - A word transfers in any cycle where `in_ready`=1 and `buffer_full`=0.
  - While `buffer_full`=1, hold `keccak_input`, `is_last`, `byte_num` and `in_ready` stable.
  - On transfer, clear `in_ready`/`is_last`/`byte_num` and increment `words_sent`. Then:
    - more FIFO words remain → `FETCH`
    - final word was `is_last` → `FIN`
    - otherwise (`rem`==0) → `PAD`
- State `PAD`: present `keccak_input`=0, `is_last`=1, `byte_num`=0, `in_ready`=1. Hold until transferred, increment `words_sent`, then go to `FIN`.
- State `FIN`: pulse `done`, clear `busy`, go to `IDLE`.
- `start` asserted in any state other than `IDLE` is ignored and is not queued.
- Never pop when `fifo_empty`=1; never pop more than `fifo_words` words.

## Timing
- Reset values:
  - `fifo_read_en`, `in_ready`, `is_last`, `busy`, `done` = 0
  - `byte_num` = 0, `keccak_input` = 0, `words_sent` = 0
  - state = `IDLE`
- All outputs are registered.
- Start to first `in_ready`: 3 cycles when the FIFO is non-empty (`IDLE`→`FETCH`→`CAPTURE`→`SEND`).
- Best-case throughput: 1 word per 3 cycles. Each stall cycle of `buffer_full` or `fifo_empty` adds one cycle.
- `done` is high 1 cycle after the final transfer. `busy` falls the same cycle `done` rises.
- `words_sent` holds its final value until the next accepted `start`.
- Reset mid-message: the next cycle returns to `IDLE` with all outputs at reset values. FIFO contents are untouched, and the in-flight word is dropped.
- Width rules:
  - `msg_len` up to 2^LEN_W−1.
  - `fifo_words` computed in LEN_W bits. For `msg_len` ≥ 2^LEN_W−7, ceil(`msg_len`/8) fits in LEN_W, so there is no overflow.

## Test plan
- `msg_len`=0 → no `fifo_read_en`; exactly one transfer with `keccak_input`=0, `is_last`=1, `byte_num`=0; `words_sent`=1; `done` pulses.
- `msg_len`=8 with FIFO word 0x0123456789ABCDEF → 1 pop; the word is sent with `is_last`=0, then the pad word is sent with `is_last`=1, `byte_num`=0; `words_sent`=2.
- `msg_len`=13 with 2 words in the FIFO → 2 pops; the second word is sent with `is_last`=1, `byte_num`=5; no pad; `words_sent`=2.
- `msg_len`=24 with `buffer_full` high for 4 cycles during word 2 and the FIFO empty for 3 cycles before word 3 → outputs stay stable during the stall; no pop while empty; 3 data words plus pad; `words_sent`=4.
- `start` pulsed again mid-message with `msg_len`=5 → ignored; the original message completes unchanged; only one `done`.
- `reset` asserted while in `SEND` → next cycle all outputs are 0 and `busy`=0; a subsequent `start` with `msg_len`=8 completes normally.

Source files
------------

// File: rtl/keccak_feeder.sv
// rtl/keccak_feeder.sv - length-driven streamer from the OCM FIFO read side into the Keccak core
//
// Purpose: on start, pops ceil(msg_len/8) 64-bit words from the FIFO and
// hands each to the Keccak core over an in_ready/buffer_full handshake.
// The final partial word is tagged with is_last/byte_num. When the length
// is a multiple of 8, a zero terminator word (is_last=1, byte_num=0) is
// appended.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, msg_len    stream request and its byte length (sampled in IDLE)
//   fifo_empty        FIFO has no readable word
//   fifo_read_en      one-cycle pop
//   fifo_read_data    FIFO head word (valid while fifo_read_en is high)
//   keccak_input      word to the core
//   in_ready          word valid to the core
//   is_last, byte_num final-word marker and its valid byte count
//   buffer_full       core backpressure
//   busy, done        message in progress / completion pulse
//   words_sent        words accepted by the core for this message
module keccak_feeder #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             fifo_empty,
  output logic             fifo_read_en,
  input  logic [63:0]      fifo_read_data,
  output logic [63:0]      keccak_input,
  output logic             in_ready,
  output logic             is_last,
  output logic [2:0]       byte_num,
  input  logic             buffer_full,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_sent
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND,
    PAD,
    FIN
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] fifo_words;
  logic [LEN_W-1:0] rd_cnt;
  logic [2:0]       rem;
  logic [LEN_W-1:0] start_words;
  logic             xfer;

  // ceil(msg_len/8); the shift leaves headroom so the +1 cannot overflow.
  assign start_words = (msg_len >> 3) + {{(LEN_W-1){1'b0}}, |msg_len[2:0]};
  assign xfer        = in_ready & ~buffer_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fifo_words   <= '0;
      rd_cnt       <= '0;
      rem          <= 3'd0;
      fifo_read_en <= 1'b0;
      keccak_input <= 64'd0;
      in_ready     <= 1'b0;
      is_last      <= 1'b0;
      byte_num     <= 3'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_sent   <= '0;
    end else begin
      fifo_read_en <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem        <= msg_len[2:0];
            fifo_words <= start_words;
            rd_cnt     <= '0;
            words_sent <= '0;
            busy       <= 1'b1;
            if (start_words == '0) begin
              // Empty message: only the terminator word goes out.
              keccak_input <= 64'd0;
              is_last      <= 1'b1;
              byte_num     <= 3'd0;
              in_ready     <= 1'b1;
              state        <= PAD;
            end else begin
              state <= FETCH;
            end
          end
        end

        FETCH: begin
          if (!fifo_empty) begin
            fifo_read_en <= 1'b1;
            rd_cnt       <= rd_cnt + 1'b1;
            state        <= CAPTURE;
          end
        end

        CAPTURE: begin
          // fifo_read_en is high this cycle, so the head word is the popped one.
          keccak_input <= fifo_read_data;
          in_ready     <= 1'b1;
          if (rd_cnt == fifo_words && rem != 3'd0) begin
            is_last  <= 1'b1;
            byte_num <= rem;
          end else begin
            is_last  <= 1'b0;
            byte_num <= 3'd0;
          end
          state <= SEND;
        end

        SEND: begin
          if (xfer) begin
            in_ready   <= 1'b0;
            is_last    <= 1'b0;
            byte_num   <= 3'd0;
            words_sent <= words_sent + 1'b1;
            if (rd_cnt != fifo_words) begin
              state <= FETCH;
            end else if (is_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              // Length was a multiple of 8: follow with the terminator word.
              keccak_input <= 64'd0;
              is_last      <= 1'b1;
              byte_num     <= 3'd0;
              in_ready     <= 1'b1;
              state        <= PAD;
            end
          end
        end

        PAD: begin
          if (xfer) begin
            in_ready   <= 1'b0;
            is_last    <= 1'b0;
            words_sent <= words_sent + 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= FIN;
          end
        end

        FIN: begin
          // done is visible in this cycle; start is not accepted until IDLE.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_feeder.sv
// tb/tb_keccak_feeder.sv - self-checking bench for keccak_feeder
module tb_keccak_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] msg_len;
  logic        fifo_empty;
  logic        fifo_read_en;
  logic [63:0] fifo_read_data;
  logic [63:0] keccak_input;
  logic        in_ready;
  logic        is_last;
  logic [2:0]  byte_num;
  logic        buffer_full;
  logic        busy;
  logic        done;
  logic [31:0] words_sent;

  keccak_feeder #(.LEN_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .msg_len(msg_len),
    .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en),
    .fifo_read_data(fifo_read_data), .keccak_input(keccak_input),
    .in_ready(in_ready), .is_last(is_last), .byte_num(byte_num),
    .buffer_full(buffer_full), .busy(busy), .done(done),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  // First-word-fall-through FIFO model: head word visible, popped on read_en.
  logic [63:0] mem [64];
  int          head = 0;
  int          tail = 0;
  logic        fifo_hold = 1'b0;
  int          pop_err = 0;

  assign fifo_empty     = (head == tail) || fifo_hold;
  assign fifo_read_data = mem[head % 64];

  always @(posedge clk) begin
    if (fifo_read_en) begin
      if (head == tail) pop_err <= pop_err + 1;
      else head <= head + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: word list derived from length and FIFO contents.
  logic [63:0] exp_data[$];
  logic        exp_last[$];
  int          exp_bn[$];
  logic [63:0] got_data[$];
  logic        got_last[$];
  int          got_bn[$];

  // mode 0: no stalls, 1: random stalls, 2: directed stalls, 3: restart attempt mid-message
  task automatic run_msg(input int len, input int mode);
    int n, r, done_cnt, pop_cnt, first_rdy, last_xfer, done_cyc, stall_cnt, hold_cnt;
    logic prev_stall, prev_empty, p_last;
    logic [63:0] p_data;
    logic [2:0] p_bn;
    logic [63:0] w;
    n = (len + 7) / 8;
    r = len % 8;
    exp_data.delete(); exp_last.delete(); exp_bn.delete();
    got_data.delete(); got_last.delete(); got_bn.delete();
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      if (len == 8 && mode == 0) w = 64'h0123456789ABCDEF;
      mem[tail % 64] = w;
      tail = tail + 1;
      exp_data.push_back(w);
      exp_last.push_back(i == n - 1 && r != 0);
      exp_bn.push_back((i == n - 1 && r != 0) ? r : 0);
    end
    if (r == 0) begin
      exp_data.push_back(64'h0); exp_last.push_back(1'b1); exp_bn.push_back(0);
    end
    done_cnt = 0; pop_cnt = 0; first_rdy = -1; last_xfer = -1; done_cyc = -1;
    stall_cnt = 0; hold_cnt = 0; prev_stall = 0; prev_empty = 0;
    p_data = 0; p_last = 0; p_bn = 0;

    @(posedge clk); #1;
    start = 1'b1; msg_len = len; buffer_full = 1'b0; fifo_hold = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("busy_set", busy, 1);
      if (in_ready && first_rdy < 0) first_rdy = cyc;
      if (prev_stall) begin
        check("stall_ready", in_ready, 1);
        check("stall_data", keccak_input, p_data);
        check("stall_last", is_last, p_last);
        check("stall_bn", byte_num, p_bn);
      end
      prev_stall = in_ready && buffer_full;
      p_data = keccak_input; p_last = is_last; p_bn = byte_num;
      if (fifo_read_en) begin
        pop_cnt++;
        check("pop_while_empty", prev_empty, 0);
      end
      prev_empty = fifo_empty;
      if (in_ready && !buffer_full) begin
        got_data.push_back(keccak_input);
        got_last.push_back(is_last);
        got_bn.push_back(byte_num);
        last_xfer = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 3 && cyc == 5) begin start = 1'b1; msg_len = 5; end
      case (mode)
        1: begin
          buffer_full = ($urandom_range(0, 2) == 0);
          fifo_hold   = ($urandom_range(0, 3) == 0);
        end
        2: begin
          buffer_full = in_ready && got_data.size() == 1 && stall_cnt < 4;
          if (buffer_full) stall_cnt++;
          fifo_hold = (got_data.size() == 2 && hold_cnt < 3);
          if (fifo_hold) hold_cnt++;
        end
        default: begin buffer_full = 1'b0; fifo_hold = 1'b0; end
      endcase
    end
    buffer_full = 1'b0; fifo_hold = 1'b0;

    if (done_cyc < 0) check("timeout_done", 0, 1);
    check("xfer_count", got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check($sformatf("word%0d_data", i), got_data[i], exp_data[i]);
      check($sformatf("word%0d_last", i), got_last[i], exp_last[i]);
      check($sformatf("word%0d_bn", i), got_bn[i], exp_bn[i]);
    end
    check("words_sent", words_sent, exp_data.size());
    check("done_count", done_cnt, 1);
    check("pop_count", pop_cnt, n);
    check("pop_error", pop_err, 0);
    check("done_latency", done_cyc, last_xfer + 1);
    if (mode == 0 && n > 0) check("first_ready_latency", first_rdy, 3);
    if (mode == 2) check("stall_cycles", stall_cnt + hold_cnt, 7);
    tail = head;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; msg_len = 0; buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_read_en", fifo_read_en, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_is_last", is_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_byte_num", byte_num, 0);
    check("rst_data", keccak_input, 0);
    check("rst_words_sent", words_sent, 0);

    run_msg(0, 0);
    run_msg(8, 0);
    run_msg(13, 0);
    run_msg(7, 0);
    run_msg(24, 2);
    run_msg(16, 3);
    for (int k = 0; k < 10; k++) run_msg($urandom_range(0, 60), 1);

    // Reset while a word is being offered.
    for (int i = 0; i < 2; i++) begin mem[tail % 64] = {$urandom, $urandom}; tail = tail + 1; end
    @(posedge clk); #1 start = 1'b1; msg_len = 16;
    @(posedge clk); #1 start = 1'b0; buffer_full = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) begin @(posedge clk); #1; end
    check("reached_send", in_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; buffer_full = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", keccak_input, 0);
    check("midrst_words_sent", words_sent, 0);
    check("midrst_read_en", fifo_read_en, 0);
    tail = head;
    run_msg(8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
